// File: rtl/bit_block_pkg.sv
// rtl/bit_block_pkg.sv - shared widths and state encodings for the bit block generator
package bit_block_pkg;

  localparam int LEN_DATA = 32;
  localparam int LEN_CNT  = 4;
  localparam int LEN_LEN  = 6;

  // Wide enough that ofs + blk_num*blk_len + (blk_num-1)*gap_len never wraps.
  localparam int LEN_TOT  = 2 * LEN_LEN + LEN_CNT;

  // Bit pointer into the work register.
  localparam int LEN_POS  = $clog2(LEN_DATA);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_BUILD = 2'd2,
    ST_DONE  = 2'd3
  } bbg_state_t;

  // Which kind of run BUILD is currently writing.
  typedef enum logic [1:0] {
    PH_OFS  = 2'd0,
    PH_ONES = 2'd1,
    PH_GAP  = 2'd2
  } bbg_phase_t;

endpackage

// File: rtl/bbg_len_check.sv
// rtl/bbg_len_check.sv - total word length and legality of a captured request
module bbg_len_check
  import bit_block_pkg::*;
(
  input  logic [LEN_CNT-1:0] blk_num,
  input  logic [LEN_LEN-1:0] blk_len,
  input  logic [LEN_LEN-1:0] gap_len,
  input  logic [LEN_LEN-1:0] ofs,
  output logic               legal,
  output logic               zero
);

  logic [LEN_TOT-1:0] total;

  // Occupied length of the word: offset, all ones runs, and the gaps between them.
  always_comb begin
    total = '0;
    if (blk_num != '0) begin
      total = LEN_TOT'(ofs)
            + LEN_TOT'(blk_num) * LEN_TOT'(blk_len)
            + (LEN_TOT'(blk_num) - LEN_TOT'(1)) * LEN_TOT'(gap_len);
    end
  end

  assign zero  = (blk_num == '0);

  // Gaps only matter when there is more than one block to separate.
  assign legal = !zero
              && (blk_len != '0)
              && !((blk_num > LEN_CNT'(1)) && (gap_len == '0))
              && (total <= LEN_TOT'(LEN_DATA));

endmodule

// File: rtl/bit_block_generator.sv
// rtl/bit_block_generator.sv - serially builds a word with a programmed number of 1-runs
module bit_block_generator
  import bit_block_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                ready,
  input  logic [LEN_CNT-1:0]  blk_num,
  input  logic [LEN_LEN-1:0]  blk_len,
  input  logic [LEN_LEN-1:0]  gap_len,
  input  logic [LEN_LEN-1:0]  ofs,
  output logic [LEN_DATA-1:0] data,
  output logic                data_enb,
  output logic [LEN_CNT-1:0]  exp_cnt,
  output logic                err
);

  bbg_state_t          state;
  bbg_phase_t          phase;
  logic [LEN_CNT-1:0]  num_r;
  logic [LEN_LEN-1:0]  len_r;
  logic [LEN_LEN-1:0]  gap_r;
  logic [LEN_LEN-1:0]  ofs_r;
  logic [LEN_LEN-1:0]  run_cnt;
  logic [LEN_CNT-1:0]  rem;
  logic [LEN_POS-1:0]  pos;
  logic [LEN_DATA-1:0] work;
  logic                reject_r;
  logic                chk_legal;
  logic                chk_zero;

  bbg_len_check u_len_check (
    .blk_num (num_r),
    .blk_len (len_r),
    .gap_len (gap_r),
    .ofs     (ofs_r),
    .legal   (chk_legal),
    .zero    (chk_zero)
  );

  // Request FSM: capture, validate, shift bits in one per cycle, then publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= PH_OFS;
      ready    <= 1'b1;
      data     <= '0;
      data_enb <= 1'b0;
      exp_cnt  <= '0;
      err      <= 1'b0;
      num_r    <= '0;
      len_r    <= '0;
      gap_r    <= '0;
      ofs_r    <= '0;
      run_cnt  <= '0;
      rem      <= '0;
      pos      <= '0;
      work     <= '0;
      reject_r <= 1'b0;
    end else begin
      data_enb <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_vld && ready) begin
            num_r <= blk_num;
            len_r <= blk_len;
            gap_r <= gap_len;
            ofs_r <= ofs;
            ready <= 1'b0;
            state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          pos      <= '0;
          work     <= '0;
          rem      <= num_r;
          reject_r <= 1'b0;
          if (chk_zero) begin
            state <= ST_DONE;
          end else if (!chk_legal) begin
            // Rejects pass through DONE so err lands on the same edge count as a zero word.
            reject_r <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_BUILD;
            if (ofs_r != '0) begin
              phase   <= PH_OFS;
              run_cnt <= ofs_r;
            end else begin
              phase   <= PH_ONES;
              run_cnt <= len_r;
            end
          end
        end

        ST_BUILD: begin
          work[pos] <= (phase == PH_ONES);
          pos       <= pos + LEN_POS'(1);
          if (run_cnt == LEN_LEN'(1)) begin
            case (phase)
              PH_OFS: begin
                phase   <= PH_ONES;
                run_cnt <= len_r;
              end
              PH_ONES: begin
                rem <= rem - LEN_CNT'(1);
                if (rem == LEN_CNT'(1)) begin
                  state <= ST_DONE;
                end else begin
                  phase   <= PH_GAP;
                  run_cnt <= gap_r;
                end
              end
              default: begin
                phase   <= PH_ONES;
                run_cnt <= len_r;
              end
            endcase
          end else begin
            run_cnt <= run_cnt - LEN_LEN'(1);
          end
        end

        ST_DONE: begin
          if (reject_r) begin
            err <= 1'b1;
          end else begin
            data     <= work;
            exp_cnt  <= num_r;
            data_enb <= 1'b1;
          end
          reject_r <= 1'b0;
          ready    <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
